gf180mcu_fd_sc_mcu7t5v0__rrarb4: RTL
====================================

Name: gf180mcu_fd_sc_mcu7t5v0__rrarb4

Overview:
- 4-requester round-robin arbiter that time-shares one downstream resource, such as a shared and4-gated datapath leg or an enable tree.
- Issues a registered one-hot grant and holds it until the owner releases, drops its request, or hits a hold-time limit.
- Inserts at least one idle cycle between owners.
- Sits between requester logic and the shared resource's enable/select inputs.

Parameters:
- HOLD_MAX, default 15: maximum consecutive cycles one owner may hold the grant. Legal range 0..255. 0 = unlimited.
- CNT_W, default 8: hold-counter width. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- CLK  input  1  rising-edge clock
- RN  input  1  asynchronous active-low reset
- REQ  input  4  request lines; bit i = requester i
- REL  input  1  current owner releases the resource (sampled only while BUSY=1)
- GNT  output  4  registered one-hot grant; all-zero when idle
- BUSY  output  1  1 while any GNT bit is set
- GID  output  2  index of the current or most recent owner
- TMO  output  1  one-cycle pulse when a grant is forcibly revoked by the hold limit

Behaviour:
- One clock, CLK. RN is asynchronous, active-low. Assertion immediately clears all state and outputs; release is sampled on CLK.
- Reset values:
  - GNT=4'b0000, BUSY=0, GID=2'd0, TMO=0.
  - Priority pointer PTR=2'd0. Hold counter CNT=0. State=IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, OWN.
- IDLE, REQ==0: stay in IDLE. Outputs unchanged, except TMO=0.
- IDLE, REQ!=0 at rising edge:
  - Winner = first set bit scanning PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - At that edge: GNT=onehot(winner), GID=winner, BUSY=1, CNT=0, state -> OWN.
  - Latency: the grant is visible in the cycle after REQ is sampled.
- OWN, each edge, in priority order:
  1. Release (REL=1, or REQ[GID]=0) -> GNT=0, BUSY=0, TMO=0, PTR=GID+1 mod 4, state -> IDLE.
  2. Otherwise, if HOLD_MAX!=0 and CNT==HOLD_MAX-1 -> forced revoke: GNT=0, BUSY=0, TMO=1 for exactly one cycle, PTR=GID+1 mod 4, state -> IDLE.
  3. Otherwise CNT=CNT+1 and the grant holds.
- The grant therefore lasts at most HOLD_MAX cycles.
- REL and the timeout on the same edge: this counts as a normal release, and TMO stays 0.
- When HOLD_MAX=0, CNT saturates at all-ones and never forces a revoke.
- Non-overlap: the cycle after any release is always IDLE with GNT=0. New arbitration happens at the following edge. Minimum gap between owners is one cycle.
- Requests from non-owners during OWN are ignored. They are not queued beyond the REQ level itself.
- REL while in IDLE is ignored.
- A revoked owner keeping REQ high is last in priority at the next arbitration (PTR has moved past it). It is re-granted only if no other request is pending.
- GID retains the last owner while BUSY=0.
- Reset mid-grant drops GNT asynchronously. After reset, PTR=0.
- REQ and REL are synchronous to CLK. Synchronisation is the requester's responsibility.

Test Plan (HOLD_MAX=4 unless stated):
- Reset, then REQ=4'b1111 held -> grants rotate 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001. Each grant lasts 4 cycles with TMO=1 on each revoke edge.
- REQ=4'b0100 for 2 cycles, then 0 -> GNT=0100 for 2 cycles, GID=2, then GNT=0. Next winner for REQ=4'b1001 is bit 3 (PTR=3).
- Owner 1 holds with REL=1 exactly on its 4th grant cycle -> GNT clears, TMO stays 0, PTR=2.
- HOLD_MAX=0, REQ=4'b0001 held for 300 cycles -> GNT=0001 continuously, TMO never asserted, CNT does not wrap.
- RN pulsed low mid-grant (GNT=0010) -> GNT=0, BUSY=0, GID=0 immediately without a clock edge. The first grant after reset with REQ=4'b0011 goes to bit 0.
- REL=1 with REQ=0 in IDLE for 5 cycles -> no state change, all outputs stay at reset values.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4.sv
// Four-requester round-robin arbiter with hold-time limit and an idle gap between owners.
// Latency: grant registered one cycle after REQ is sampled; every output comes straight from a flop.
// Backpressure: non-owners simply keep REQ high; the level is the only queue, and no request is latched.
module gf180mcu_fd_sc_mcu7t5v0__rrarb4 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic [3:0] REQ,
    input  logic       REL,
    output logic [3:0] GNT,
    output logic       BUSY,
    output logic [1:0] GID,
    output logic       TMO
);

    typedef enum logic {IDLE, OWN} state_t;

    // A zero hold limit disables the forced revoke entirely.
    localparam bit LIMITED = (HOLD_MAX != 0);
    // The limit is compared against the count of cycles already held,
    // so the last allowed cycle sees CNT == HOLD_MAX-1.
    localparam int LIM_I = LIMITED ? HOLD_MAX - 1 : 0;
    localparam logic [CNT_W-1:0] LIM = LIM_I[CNT_W-1:0];

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic [1:0] win;
    logic       win_vld;
    logic       rel_now;

    // Rotating priority scan starting at ptr; scanning from the far end
    // down lets the nearest set bit overwrite the others.
    always_comb begin
        win     = ptr;
        win_vld = |REQ;
        for (int k = 3; k >= 0; k--) begin
            if (REQ[ptr + 2'(k)]) begin
                win = ptr + 2'(k);
            end
        end
    end

    // The owner gives up the resource by pulsing REL or dropping its own request.
    always_comb begin
        rel_now = REL || !REQ[GID];
    end

    // Arbitration state machine; every output is a register updated here.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= '0;
            GNT   <= 4'b0000;
            BUSY  <= 1'b0;
            GID   <= 2'd0;
            TMO   <= 1'b0;
        end else begin
            TMO <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        GNT   <= 4'b0001 << win;
                        GID   <= win;
                        BUSY  <= 1'b1;
                        cnt   <= '0;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (rel_now) begin
                        // A release on the timeout edge wins, so TMO stays low.
                        GNT   <= 4'b0000;
                        BUSY  <= 1'b0;
                        ptr   <= GID + 2'd1;
                        state <= IDLE;
                    end else if (LIMITED && cnt == LIM) begin
                        GNT   <= 4'b0000;
                        BUSY  <= 1'b0;
                        TMO   <= 1'b1;
                        ptr   <= GID + 2'd1;
                        state <= IDLE;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        // Saturate so an unlimited hold never wraps the counter.
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
